// File: rtl/debug_monitor.sv
// Single-step / free-run controller for a soft core, with snapshot and event
// counters published to an LCD slot map.
module debug_monitor #(
    parameter logic [31:0] RUN_DIV = 32'd50_000_000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        input_valid,
    input  logic [31:0] input_value,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic        dmem_wen,
    input  logic        exit,
    input  logic [5:0]  display_number,
    output logic        cpu_ce,
    output logic        display_valid,
    output logic [39:0] display_name,
    output logic [31:0] display_value
);

    localparam logic [1:0] S_HALT = 2'd0;
    localparam logic [1:0] S_STEP = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state;
    logic [31:0] div_cnt;
    logic [31:0] pc_snap;
    logic [31:0] inst_snap;
    logic [31:0] daddr_snap;
    logic [31:0] wdata_snap;
    logic [31:0] cycle_cnt;
    logic [31:0] store_cnt;

    // Command handshake: input_valid is a one-cycle strobe with no ready/back-
    // pressure; input_value is looked at only in a cycle where input_valid=1,
    // and a command that the current state does not accept is simply dropped.
    logic cmd_step;
    logic cmd_run;
    logic cmd_halt;
    logic div_last;

    assign cmd_step = input_valid && (input_value == 32'd1);
    assign cmd_run  = input_valid && (input_value == 32'd2);
    assign cmd_halt = input_valid && (input_value == 32'd3);
    assign div_last = (div_cnt == (RUN_DIV - 32'd1));

    // Decoded from registers only so the core enable never glitches on inputs.
    assign cpu_ce = (state == S_STEP) || ((state == S_RUN) && div_last);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state   <= S_HALT;
            div_cnt <= 32'd0;
        end else if (exit) begin
            state   <= S_DONE;
            div_cnt <= 32'd0;
        end else begin
            case (state)
                S_HALT: begin
                    if (cmd_step) begin
                        state <= S_STEP;
                    end else if (cmd_run) begin
                        state   <= S_RUN;
                        div_cnt <= 32'd0;
                    end
                end
                S_STEP: begin
                    state <= S_HALT;
                end
                S_RUN: begin
                    if (cmd_halt) begin
                        state   <= S_HALT;
                        div_cnt <= 32'd0;
                    end else if (div_last) begin
                        div_cnt <= 32'd0;
                    end else begin
                        div_cnt <= div_cnt + 32'd1;
                    end
                end
                default: begin
                    state <= S_DONE;
                end
            endcase
        end
    end

    // Snapshots hold the operands the core sees before the enabled step.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            pc_snap    <= 32'd0;
            inst_snap  <= 32'd0;
            daddr_snap <= 32'd0;
            wdata_snap <= 32'd0;
            cycle_cnt  <= 32'd0;
            store_cnt  <= 32'd0;
        end else if (cpu_ce) begin
            pc_snap    <= pc;
            inst_snap  <= inst;
            daddr_snap <= dmem_addr;
            wdata_snap <= dmem_wdata;
            cycle_cnt  <= cycle_cnt + 32'd1;
            if (dmem_wen) begin
                store_cnt <= store_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            display_valid <= 1'b0;
            display_name  <= 40'd0;
            display_value <= 32'd0;
        end else begin
            display_valid <= 1'b1;
            case (display_number)
                6'd1: begin
                    display_name  <= "   PC";
                    display_value <= pc_snap;
                end
                6'd2: begin
                    display_name  <= " INST";
                    display_value <= inst_snap;
                end
                6'd3: begin
                    display_name  <= "DADDR";
                    display_value <= daddr_snap;
                end
                6'd4: begin
                    display_name  <= "WDATA";
                    display_value <= wdata_snap;
                end
                6'd5: begin
                    display_name  <= "CYCLE";
                    display_value <= cycle_cnt;
                end
                6'd6: begin
                    display_name  <= "STORE";
                    display_value <= store_cnt;
                end
                6'd7: begin
                    display_name  <= "STATE";
                    display_value <= {30'd0, state};
                end
                default: begin
                    display_valid <= 1'b0;
                    display_name  <= 40'd0;
                    display_value <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_monitor.sv
// Bench for debug_monitor: directed vector table, hand sequences for the
// store/wrap/reset corners, and randomized traffic against a mode-level model.
module tb_debug_monitor;

    localparam logic [31:0] RUN_DIV = 32'd4;

    logic        clock;
    logic        resetn;
    logic        input_valid;
    logic [31:0] input_value;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_wen;
    logic        exit;
    logic [5:0]  display_number;
    logic        cpu_ce;
    logic        display_valid;
    logic [39:0] display_name;
    logic [31:0] display_value;

    debug_monitor #(.RUN_DIV(RUN_DIV)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .input_valid    (input_valid),
        .input_value    (input_value),
        .pc             (pc),
        .inst           (inst),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_wen       (dmem_wen),
        .exit           (exit),
        .display_number (display_number),
        .cpu_ce         (cpu_ce),
        .display_valid  (display_valid),
        .display_name   (display_name),
        .display_value  (display_value)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors;
    int miscompares;

    // ---------------- reference model ----------------
    // Modes: 0 halted, 1 single step pending, 2 free running, 3 finished.
    int          m_mode;
    longint      m_run_cycles;
    logic [31:0] m_snap [1:4];
    logic [31:0] m_cycle;
    logic [31:0] m_store;
    logic        e_valid;
    logic [39:0] e_name;
    logic [31:0] e_value;

    function automatic logic model_ce();
        if (m_mode == 1) return 1'b1;
        if (m_mode == 2 && (m_run_cycles % RUN_DIV) == longint'(RUN_DIV) - 1) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_run_cycles = 0;
        for (int i = 1; i <= 4; i++) m_snap[i] = 32'd0;
        m_cycle = 32'd0;
        m_store = 32'd0;
        e_valid = 1'b0;
        e_name  = 40'd0;
        e_value = 32'd0;
    endtask

    task automatic model_slot(input logic [5:0] dn);
        e_valid = 1'b1;
        case (dn)
            6'd1: begin e_name = "   PC"; e_value = m_snap[1]; end
            6'd2: begin e_name = " INST"; e_value = m_snap[2]; end
            6'd3: begin e_name = "DADDR"; e_value = m_snap[3]; end
            6'd4: begin e_name = "WDATA"; e_value = m_snap[4]; end
            6'd5: begin e_name = "CYCLE"; e_value = m_cycle; end
            6'd6: begin e_name = "STORE"; e_value = m_store; end
            6'd7: begin e_name = "STATE"; e_value = 32'(m_mode); end
            default: begin e_valid = 1'b0; e_name = 40'd0; e_value = 32'd0; end
        endcase
    endtask

    task automatic model_edge(input logic iv, input logic [31:0] val, input logic ex,
                              input logic wen, input logic [5:0] dn, input logic rn);
        logic ce;
        if (!rn) begin
            model_reset();
            return;
        end
        ce = model_ce();
        model_slot(dn);
        if (ce) begin
            m_snap[1] = pc;
            m_snap[2] = inst;
            m_snap[3] = dmem_addr;
            m_snap[4] = dmem_wdata;
            m_cycle = m_cycle + 32'd1;
            if (wen) m_store = m_store + 32'd1;
        end
        if (ex) begin
            m_mode = 3;
        end else begin
            case (m_mode)
                0: if (iv && val == 32'd1) m_mode = 1;
                   else if (iv && val == 32'd2) begin m_mode = 2; m_run_cycles = 0; end
                1: m_mode = 0;
                2: if (iv && val == 32'd3) m_mode = 0;
                   else m_run_cycles = m_run_cycles + 1;
                default: m_mode = 3;
            endcase
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Inputs are applied just after a rising edge; outputs are sampled on the
    // falling edge, then the model advances across the following rising edge.
    task automatic tick(input logic iv, input logic [31:0] val, input logic ex,
                        input logic wen, input logic [5:0] dn, input logic rn,
                        input logic has_exp, input logic exp_ce);
        input_valid    = iv;
        input_value    = val;
        exit           = ex;
        dmem_wen       = wen;
        display_number = dn;
        resetn         = rn;
        @(negedge clock);
        check("cpu_ce", {39'd0, cpu_ce}, {39'd0, model_ce()});
        if (has_exp) check("cpu_ce_table", {39'd0, cpu_ce}, {39'd0, exp_ce});
        check("display_valid", {39'd0, display_valid}, {39'd0, e_valid});
        check("display_name", display_name, e_name);
        check("display_value", {8'd0, display_value}, {8'd0, e_value});
        model_edge(iv, val, ex, wen, dn, rn);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input logic [5:0] dn);
        tick(1'b0, 32'd0, 1'b0, 1'b0, dn, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic cmd(input logic [31:0] val, input logic [5:0] dn);
        tick(1'b1, val, 1'b0, 1'b0, dn, 1'b1, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] val;
        logic        ex;
        logic        wen;
        logic [5:0]  dn;
        logic        rn;
        logic        exp_ce;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic iv, input logic [31:0] val, input logic ex,
                                input logic wen, input logic [5:0] dn, input logic rn,
                                input logic exp_ce);
        vec_t v;
        v.iv = iv; v.val = val; v.ex = ex; v.wen = wen; v.dn = dn; v.rn = rn; v.exp_ce = exp_ce;
        return v;
    endfunction

    initial begin
        vectors = 0;
        miscompares = 0;
        input_valid = 1'b0;
        input_value = 32'd0;
        pc = 32'd0;
        inst = 32'd0;
        dmem_addr = 32'd0;
        dmem_wdata = 32'd0;
        dmem_wen = 1'b0;
        exit = 1'b0;
        display_number = 6'd0;
        resetn = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;

        // Directed table: step, run with RUN_DIV=4, halt on a due pulse, exit into DONE.
        tbl.push_back(mk(1, 32'd1, 0, 0, 6'd5, 1, 0));
        tbl.push_back(mk(0, 32'd0, 0, 1, 6'd5, 1, 1));
        tbl.push_back(mk(0, 32'd0, 0, 0, 6'd5, 1, 0));
        tbl.push_back(mk(1, 32'd2, 0, 0, 6'd5, 1, 0));
        for (int k = 0; k < 2; k++) begin
            tbl.push_back(mk(0, 32'd0, 0, 0, 6'd5, 1, 0));
            tbl.push_back(mk(0, 32'd0, 0, 0, 6'd5, 1, 0));
            tbl.push_back(mk(1, 32'd1, 0, 0, 6'd7, 1, 0));
            tbl.push_back(mk(0, 32'd0, 0, 0, 6'd5, 1, 1));
        end
        tbl.push_back(mk(0, 32'd0, 0, 0, 6'd7, 1, 0));
        tbl.push_back(mk(0, 32'd0, 0, 0, 6'd7, 1, 0));
        tbl.push_back(mk(0, 32'd0, 0, 0, 6'd7, 1, 0));
        tbl.push_back(mk(1, 32'd3, 0, 0, 6'd7, 1, 1));
        tbl.push_back(mk(0, 32'd0, 0, 0, 6'd7, 1, 0));
        tbl.push_back(mk(0, 32'd0, 0, 0, 6'd7, 1, 0));
        tbl.push_back(mk(1, 32'd7, 0, 0, 6'd7, 1, 0));
        tbl.push_back(mk(1, 32'd2, 0, 0, 6'd7, 1, 0));
        tbl.push_back(mk(1, 32'd2, 1, 0, 6'd7, 1, 0));
        tbl.push_back(mk(0, 32'd0, 0, 0, 6'd7, 1, 0));
        tbl.push_back(mk(1, 32'd1, 0, 0, 6'd7, 1, 0));
        tbl.push_back(mk(1, 32'd2, 0, 0, 6'd7, 1, 0));
        tbl.push_back(mk(0, 32'd0, 0, 0, 6'd7, 1, 0));
        tbl.push_back(mk(0, 32'd0, 0, 0, 6'd7, 0, 0));
        tbl.push_back(mk(0, 32'd0, 0, 0, 6'd7, 1, 0));
        tbl.push_back(mk(0, 32'd0, 0, 0, 6'd7, 1, 0));
        foreach (tbl[i]) begin
            pc = 32'h100 + 32'(i) * 4;
            inst = $urandom;
            dmem_addr = $urandom;
            dmem_wdata = $urandom;
            tick(tbl[i].iv, tbl[i].val, tbl[i].ex, tbl[i].wen, tbl[i].dn, tbl[i].rn,
                 1'b1, tbl[i].exp_ce);
        end

        // Store snapshot on a step, then read back PC/INST/STORE and an empty slot.
        tick(0, 32'd0, 0, 0, 6'd0, 0, 0, 0);
        cmd(32'd1, 6'd0);
        pc = 32'h0000_0010;
        inst = 32'h00A0_0093;
        dmem_addr = 32'h0000_0200;
        dmem_wdata = 32'hDEAD_BEEF;
        tick(0, 32'd0, 0, 1, 6'd1, 1, 1, 1);
        pc = 32'h0;
        inst = 32'h0;
        idle(6'd2);
        idle(6'd6);
        idle(6'd9);
        idle(6'd63);
        idle(6'd0);

        // Cycle counter across its wrap point.
        idle(6'd5);
        force dut.cycle_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.cycle_cnt;
        m_cycle = 32'hFFFF_FFFE;
        cmd(32'd1, 6'd5);
        idle(6'd5);
        cmd(32'd1, 6'd5);
        idle(6'd5);
        idle(6'd5);
        idle(6'd5);

        // Reset while running one cycle before a pulse is due.
        cmd(32'd2, 6'd5);
        for (int g = 0; g < 16 && !(m_mode == 2 && (m_run_cycles % RUN_DIV) == longint'(RUN_DIV) - 2); g++)
            idle(6'd5);
        tick(0, 32'd0, 0, 0, 6'd5, 0, 1, 0);
        tick(0, 32'd0, 0, 0, 6'd1, 1, 1, 0);
        for (int s = 2; s <= 8; s++) tick(0, 32'd0, 0, 0, 6'(s), 1, 1, 0);
        idle(6'd7);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            logic iv;
            logic ex;
            logic rn;
            logic [5:0] dn;
            pc = $urandom;
            inst = $urandom;
            dmem_addr = $urandom;
            dmem_wdata = $urandom;
            iv = ($urandom_range(0, 3) == 0);
            ex = ($urandom_range(0, 149) == 0);
            rn = ($urandom_range(0, 99) != 0);
            dn = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 8));
            tick(iv, 32'($urandom_range(0, 4)), ex, 1'($urandom_range(0, 1)), dn, rn, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
